// File: rtl/rv32_mem_port_arbiter.sv
// Shares one single-port memory between the RV32 fetch and load/store ports.
// One transaction in flight; data wins unless fetch has waited STARVE_MAX data grants.
module rv32_mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_en_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                stall_o
);

    localparam logic [1:0] LatInit   = 2'(MEM_LAT - 1);
    localparam logic [3:0] StarveTop = 4'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e              state_q;
    logic                owner_q;  // 1 = data port owns the read in flight
    logic [1:0]          lat_q;
    logic [3:0]          starve_q;
    logic                if_rvalid_q, d_rvalid_q;
    logic [DATA_W-1:0]   if_rdata_q, d_rdata_q;
    logic                grant_ok, fetch_pri;

    always_comb begin
        grant_ok  = rst_n && (state_q != StWait);
        fetch_pri = (starve_q == StarveTop);
        if_gnt_o  = grant_ok & if_req_i & (~d_req_i | fetch_pri);
        d_gnt_o   = grant_ok & d_req_i & ~(if_req_i & fetch_pri);

        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_be_o    = '0;
        if (d_gnt_o) begin
            mem_en_o    = 1'b1;
            mem_we_o    = d_we_i;
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_we_i ? d_wdata_i : '0;
            mem_be_o    = d_we_i ? d_be_i : '1;
        end else if (if_gnt_o) begin
            mem_en_o   = 1'b1;
            mem_addr_o = if_addr_i;
            mem_be_o   = '1;
        end

        stall_o = rst_n & ((if_req_i & ~if_gnt_o) | (d_req_i & ~d_gnt_o) |
                           (state_q == StWait));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            lat_q       <= '0;
            starve_q    <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;

            if (if_gnt_o || !if_req_i) begin
                starve_q <= '0;
            end else if (d_gnt_o && (starve_q != StarveTop)) begin
                starve_q <= starve_q + 4'd1;
            end

            unique case (state_q)
                StIdle, StResp: begin
                    // Stores complete in the grant cycle, so only reads enter WAIT.
                    if (d_gnt_o && !d_we_i) begin
                        state_q <= StWait;
                        owner_q <= 1'b1;
                        lat_q   <= LatInit;
                    end else if (if_gnt_o) begin
                        state_q <= StWait;
                        owner_q <= 1'b0;
                        lat_q   <= LatInit;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StWait: begin
                    if (lat_q == 2'd0) begin
                        state_q <= StResp;
                        if (owner_q) begin
                            d_rdata_q  <= mem_rdata_i;
                            d_rvalid_q <= 1'b1;
                        end else begin
                            if_rdata_q  <= mem_rdata_i;
                            if_rvalid_q <= 1'b1;
                        end
                    end else begin
                        lat_q <= lat_q - 2'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign if_rvalid_o = if_rvalid_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rdata_o   = d_rdata_q;

endmodule

// File: tb/tb_rv32_mem_port_arbiter.sv
// Directed bench: MEM_LAT=1 instance for grant/priority/reset cases,
// MEM_LAT=3 instance for back-to-back fetch pacing.
module tb_rv32_mem_port_arbiter;

    logic clk, rst_n;
    int   n_total = 0;
    int   n_bad   = 0;

    // Instance A (MEM_LAT=1)
    logic        if_req, if_gnt, if_rvalid, d_req, d_we, d_gnt, d_rvalid;
    logic        mem_en, mem_we, stall;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  d_be, mem_be;

    // Instance B (MEM_LAT=3)
    logic        b_if_req, b_if_gnt, b_if_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic        b_mem_en, b_mem_we, b_stall;
    logic [31:0] b_if_addr, b_if_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_d_be, b_mem_be;

    rv32_mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_be_i(d_be), .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_be_o(mem_be), .mem_rdata_i(mem_rdata),
        .stall_o(stall)
    );

    rv32_mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .if_req_i(b_if_req), .if_addr_i(b_if_addr), .if_gnt_o(b_if_gnt),
        .if_rvalid_o(b_if_rvalid), .if_rdata_o(b_if_rdata),
        .d_req_i(b_d_req), .d_we_i(b_d_we), .d_addr_i(b_d_addr), .d_wdata_i(b_d_wdata),
        .d_be_i(b_d_be), .d_gnt_o(b_d_gnt), .d_rvalid_o(b_d_rvalid), .d_rdata_o(b_d_rdata),
        .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_be_o(b_mem_be), .mem_rdata_i(b_mem_rdata),
        .stall_o(b_stall)
    );

    // Memory contents: 0x10 holds a NOP, everything else is {addr[15:0], 5A5A}.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a == 32'h10) ? 32'h0000_0013 : {a[15:0], 16'h5A5A};
    endfunction

    logic [31:0] a_pipe;
    logic [31:0] b_pipe [3];
    always_ff @(posedge clk) begin
        a_pipe    <= mem_fn(mem_addr);
        b_pipe[0] <= mem_fn(b_mem_addr);
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign mem_rdata   = a_pipe;
    assign b_mem_rdata = b_pipe[2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] b_lo;
        rst_n = 1'b0;
        {if_req, d_req, d_we} = '0;
        {if_addr, d_addr, d_wdata, d_be} = '0;
        {b_if_req, b_d_req, b_d_we} = '0;
        {b_if_addr, b_d_addr, b_d_wdata, b_d_be} = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctl", 32'({if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, stall}), 0);
        check("rst_rdata", if_rdata | d_rdata | mem_addr, 0);
        rst_n = 1'b1;
        next_cycle();

        // Single fetch from 0x10
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        check("t1_gnt", {if_gnt, d_gnt, mem_en, mem_we, stall}, 5'b10100);
        check("t1_addr", mem_addr, 32'h10);
        next_cycle(); if_req = 1'b0;
        @(negedge clk);
        check("t1_wait", {if_rvalid, stall}, 2'b01);
        next_cycle();
        @(negedge clk);
        check("t1_rv", {if_rvalid, stall}, 2'b10);
        check("t1_rdata", if_rdata, 32'h0000_0013);
        next_cycle();
        @(negedge clk);
        check("t1_hold", {if_rvalid, if_rdata}, {1'b0, 32'h0000_0013});

        // Simultaneous fetch and load: data first, fetch granted in load's rvalid cycle
        next_cycle();
        if_req = 1'b1; if_addr = 32'h20; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        @(negedge clk);
        check("t2_dgnt", {d_gnt, if_gnt, stall}, 3'b101);
        check("t2_addr", mem_addr, 32'h100);
        next_cycle(); d_req = 1'b0;
        @(negedge clk);
        check("t2_wait", {if_gnt, d_rvalid}, 2'b00);
        next_cycle();
        @(negedge clk);
        check("t2_drv", {d_rvalid, if_gnt}, 2'b11);
        check("t2_drdata", d_rdata, 32'h0100_5A5A);
        check("t2_faddr", mem_addr, 32'h20);
        next_cycle(); if_req = 1'b0;
        @(negedge clk);
        check("t2_fwait", {if_rvalid, d_rvalid}, 2'b00);
        next_cycle();
        @(negedge clk);
        check("t2_frv", {if_rvalid, d_rvalid}, 2'b10);
        check("t2_frdata", if_rdata, 32'h0020_5A5A);
        check("t2_dhold", d_rdata, 32'h0100_5A5A);

        // Store completes in its grant cycle; fetch granted the next cycle
        next_cycle();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF; d_be = 4'b0011;
        if_req = 1'b1; if_addr = 32'h44;
        @(negedge clk);
        check("t3_st", {d_gnt, if_gnt, mem_en, mem_we}, 4'b1011);
        check("t3_be", mem_be, 4'b0011);
        check("t3_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("t3_addr", mem_addr, 32'h40);
        next_cycle(); d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        check("t3_fgnt", {if_gnt, d_rvalid, mem_we}, 3'b100);
        next_cycle(); if_req = 1'b0;
        @(negedge clk);
        check("t3_nodrv", d_rvalid, 0);
        next_cycle();
        @(negedge clk);
        check("t3_frv", {if_rvalid, d_rvalid, if_rdata}, {2'b10, 32'h0044_5A5A});

        // Starvation: continuous stores with fetch held
        next_cycle();
        if_req = 1'b1; if_addr = 32'h80;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h60; d_wdata = 32'h1234_5678; d_be = 4'hF;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("t4_dgnt%0d", c), d_gnt, 32'((c < 4) || (c >= 6 && c < 10)));
            check($sformatf("t4_ignt%0d", c), if_gnt, 32'((c == 4) || (c == 10)));
            next_cycle();
        end
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        repeat (2) next_cycle();

        // Reset during WAIT of a load drops the response
        d_req = 1'b1; d_addr = 32'h200;
        @(negedge clk);
        check("t6_gnt", d_gnt, 1);
        next_cycle(); d_req = 1'b0;
        @(negedge clk);
        check("t6_wait", stall, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rstout", {d_rvalid, if_rvalid, stall, mem_en}, 4'b0000);
        check("t6_rdata", d_rdata | if_rdata, 0);
        next_cycle(); rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("t6_norv%0d", c), {d_rvalid, if_rvalid}, 2'b00);
            next_cycle();
        end
        if_req = 1'b1; if_addr = 32'h10;
        @(negedge clk);
        check("t6_next_gnt", if_gnt, 1);
        next_cycle(); if_req = 1'b0;
        next_cycle();
        @(negedge clk);
        check("t6_next_rv", {if_rvalid, if_rdata}, {1'b1, 32'h0000_0013});

        // MEM_LAT=3 back-to-back fetches
        next_cycle();
        b_if_req = 1'b1; b_if_addr = 32'h30;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            check($sformatf("b_stall%0d", c), b_stall, 32'(c % 4 != 0));
            check($sformatf("b_rv%0d", c), b_if_rvalid, 32'(c != 0 && c % 4 == 0));
            check($sformatf("b_gnt%0d", c), b_if_gnt, 32'(c % 4 == 0));
            if (c != 0 && c % 4 == 0) begin
                b_lo = 16'h0030 + 16'(4 * (c / 4 - 1));
                check($sformatf("b_rdata%0d", c), b_if_rdata, {b_lo, 16'h5A5A});
            end
            next_cycle();
            if (c % 4 == 0) b_if_addr = 32'h30 + 32'(4 * (c / 4 + 1));
        end
        b_if_req = 1'b0;
        repeat (5) next_cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
